// File: rtl/ads1115_pkg.sv
// ads1115_pkg
//   Shared definitions for the ADS1115 channel scanner:
//   - register pointer bytes (CONFIG / CONVERSION)
//   - config-word field encodings (OS, MUX, PGA, MODE, DR, comparator)
//   - scanner state encoding
//   - helpers: config-word builder and channel-mask search functions
package ads1115_pkg;

  // Register pointer bytes
  localparam logic [7:0] PTR_CONV   = 8'h00;
  localparam logic [7:0] PTR_CONFIG = 8'h01;

  // Config-word field encodings
  localparam logic       OS_START     = 1'b1;     // start a single conversion
  localparam logic       MUX_SE       = 1'b1;     // MUX[2]=1: AINn versus GND
  localparam logic       MODE_SINGLE  = 1'b1;     // single-shot mode
  localparam logic [2:0] PGA_4V096    = 3'b001;   // +/-4.096 V full scale
  localparam logic [2:0] DR_128SPS    = 3'b100;   // 128 samples per second
  localparam logic [4:0] COMP_DISABLE = 5'b00011; // comparator off, ALERT high-Z

  // Width of the wait timer; covers several hundred ms at 50 MHz
  localparam int TIMER_W = 24;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_CFG     = 4'd1,
    ST_W_CFG      = 4'd2,
    ST_CONV_WAIT  = 4'd3,
    ST_SET_PTR    = 4'd4,
    ST_W_PTR      = 4'd5,
    ST_RD         = 4'd6,
    ST_W_RD       = 4'd7,
    ST_STORE      = 4'd8,
    ST_NEXT       = 4'd9,
    ST_POLL_PTR   = 4'd10,
    ST_W_POLL_PTR = 4'd11,
    ST_POLL_RD    = 4'd12,
    ST_W_POLL_RD  = 4'd13
  } state_t;

  // Single-shot, single-ended config word for channel ch.
  function automatic logic [15:0] cfg_word(input logic [1:0] ch,
                                           input logic [2:0] pga,
                                           input logic [2:0] dr);
    return {OS_START, MUX_SE, ch, pga, MODE_SINGLE, dr, COMP_DISABLE};
  endfunction

  // Index of the lowest set bit of mask (0 when mask is empty).
  function automatic logic [1:0] lowest_set(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = mask[i] ? 2'(i) : idx;
    end
    return idx;
  endfunction

  // {found, idx}: lowest set bit of mask strictly above ch.
  function automatic logic [2:0] next_set(input logic [3:0] mask,
                                          input logic [1:0] ch);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      res = (mask[i] && (i > int'(ch))) ? {1'b1, 2'(i)} : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/ads1115_wait_timer.sv
// ads1115_wait_timer
//   Loadable down-counter. After a load of value V the terminal pulse tc
//   is high in the (V+1)-th cycle, so loading N-1 gives an N-cycle wait.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      load load_val and start counting
//   load_val  initial count
//   tc        one-cycle terminal-count pulse
module ads1115_wait_timer
  import ads1115_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               tc
);

  logic [TIMER_W-1:0] cnt_r;
  logic               run_r;

  // Count register: loads, then decrements to zero and stops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {TIMER_W{1'b0}};
      run_r <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == {TIMER_W{1'b0}}) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - {{(TIMER_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign tc = run_r && (cnt_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/ads1115_channel_scanner.sv
// ads1115_channel_scanner
//   Drives an I2C transaction engine through ADS1115 single-shot conversions
//   on the channels selected by CH_MASK: config write, conversion wait,
//   pointer write to CONV, 16-bit read. Each result is published with a
//   one-cycle sample_valid and kept per channel in result_flat.
//   Build option ADS1115_READY_POLL_EN: the fixed conversion wait becomes
//   OS-bit polling (gap, pointer-only write of CONFIG, read; repeat until
//   bit15 = 1).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   scan_en / scan_once            continuous passes / single pass request
//   txn_start, txn_addr, txn_rw,   transaction request to the engine,
//   txn_reg, txn_wdata,            fields held from txn_start to txn_done
//   txn_ptr_only
//   txn_busy, txn_done, txn_nack,  engine status and read data
//   txn_rdata
//   sample_valid/ch/data           published sample
//   result_flat                    latest result per channel, AINn at [16n+:16]
//   busy                           pass in progress
//   err_count                      saturating NACK count
module ads1115_channel_scanner
  import ads1115_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR         = 7'b1001000,
  parameter logic [3:0] CH_MASK          = 4'b1111,
  parameter logic [2:0] PGA              = PGA_4V096,
  parameter logic [2:0] DR               = DR_128SPS,
  parameter int         CONV_WAIT_CYCLES = 400000,
  parameter int         POLL_GAP_CYCLES  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic        scan_once,
  output logic        txn_start,
  output logic [6:0]  txn_addr,
  output logic        txn_rw,
  output logic [7:0]  txn_reg,
  output logic [15:0] txn_wdata,
  output logic        txn_ptr_only,
  input  logic        txn_busy,
  input  logic        txn_done,
  input  logic        txn_nack,
  input  logic [15:0] txn_rdata,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic [15:0] sample_data,
  output logic [63:0] result_flat,
  output logic        busy,
  output logic [7:0]  err_count
);

`ifdef ADS1115_READY_POLL_EN
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(POLL_GAP_CYCLES - 1);
  logic unused_param_s;
  assign unused_param_s = ^CONV_WAIT_CYCLES;
`else
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(CONV_WAIT_CYCLES - 1);
  logic unused_param_s;
  assign unused_param_s = ^POLL_GAP_CYCLES;
`endif

  state_t      state_r, state_nxt;
  logic [1:0]  ch_r;
  logic [15:0] rdata_r;

  logic        issue_s, issue_rw_s, issue_ptr_s;
  logic [7:0]  issue_reg_s;
  logic [15:0] issue_wdata_s;
  logic        nack_s, rd_cap_s, store_s;
  logic        pass_start_s, pass_end_s, adv_s;
  logic [1:0]  adv_ch_s;
  logic [2:0]  nxt_s;
  logic        tmr_load_s, tmr_tc_s;

  ads1115_wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (WAIT_LOAD),
    .tc       (tmr_tc_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_nxt     = state_r;
    issue_s       = 1'b0;
    issue_rw_s    = 1'b0;
    issue_reg_s   = PTR_CONV;
    issue_wdata_s = 16'h0000;
    issue_ptr_s   = 1'b0;
    nack_s        = 1'b0;
    rd_cap_s      = 1'b0;
    store_s       = 1'b0;
    pass_start_s  = 1'b0;
    pass_end_s    = 1'b0;
    adv_s         = 1'b0;
    adv_ch_s      = ch_r;
    tmr_load_s    = 1'b0;
    nxt_s         = next_set(CH_MASK, ch_r);
    case (state_r)
      ST_IDLE: begin
        if ((scan_en || scan_once) && (CH_MASK != 4'b0000)) begin
          pass_start_s = 1'b1;
          state_nxt    = ST_WR_CFG;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_CFG: begin
        if (!txn_busy) begin
          issue_s       = 1'b1;
          issue_reg_s   = PTR_CONFIG;
          issue_wdata_s = cfg_word(ch_r, PGA, DR);
          state_nxt     = ST_W_CFG;
        end else begin
          state_nxt = ST_WR_CFG;
        end
      end
      ST_W_CFG: begin
        if (txn_done && txn_nack) begin
          nack_s    = 1'b1;
          state_nxt = ST_NEXT;
        end else if (txn_done) begin
          tmr_load_s = 1'b1;
          state_nxt  = ST_CONV_WAIT;
        end else begin
          state_nxt = ST_W_CFG;
        end
      end
      ST_CONV_WAIT: begin
        if (tmr_tc_s) begin
`ifdef ADS1115_READY_POLL_EN
          state_nxt = ST_POLL_PTR;
`else
          state_nxt = ST_SET_PTR;
`endif
        end else begin
          state_nxt = ST_CONV_WAIT;
        end
      end
`ifdef ADS1115_READY_POLL_EN
      ST_POLL_PTR: begin
        if (!txn_busy) begin
          issue_s     = 1'b1;
          issue_reg_s = PTR_CONFIG;
          issue_ptr_s = 1'b1;
          state_nxt   = ST_W_POLL_PTR;
        end else begin
          state_nxt = ST_POLL_PTR;
        end
      end
      ST_W_POLL_PTR: begin
        if (txn_done && txn_nack) begin
          nack_s    = 1'b1;
          state_nxt = ST_NEXT;
        end else if (txn_done) begin
          state_nxt = ST_POLL_RD;
        end else begin
          state_nxt = ST_W_POLL_PTR;
        end
      end
      ST_POLL_RD: begin
        if (!txn_busy) begin
          issue_s     = 1'b1;
          issue_rw_s  = 1'b1;
          issue_reg_s = PTR_CONFIG;
          state_nxt   = ST_W_POLL_RD;
        end else begin
          state_nxt = ST_POLL_RD;
        end
      end
      ST_W_POLL_RD: begin
        if (txn_done && txn_nack) begin
          nack_s    = 1'b1;
          state_nxt = ST_NEXT;
        end else if (txn_done && txn_rdata[15]) begin
          // OS bit back at 1: conversion finished
          state_nxt = ST_SET_PTR;
        end else if (txn_done) begin
          tmr_load_s = 1'b1;
          state_nxt  = ST_CONV_WAIT;
        end else begin
          state_nxt = ST_W_POLL_RD;
        end
      end
`endif
      ST_SET_PTR: begin
        if (!txn_busy) begin
          issue_s     = 1'b1;
          issue_reg_s = PTR_CONV;
          issue_ptr_s = 1'b1;
          state_nxt   = ST_W_PTR;
        end else begin
          state_nxt = ST_SET_PTR;
        end
      end
      ST_W_PTR: begin
        if (txn_done && txn_nack) begin
          nack_s    = 1'b1;
          state_nxt = ST_NEXT;
        end else if (txn_done) begin
          state_nxt = ST_RD;
        end else begin
          state_nxt = ST_W_PTR;
        end
      end
      ST_RD: begin
        if (!txn_busy) begin
          issue_s     = 1'b1;
          issue_rw_s  = 1'b1;
          issue_reg_s = PTR_CONV;
          state_nxt   = ST_W_RD;
        end else begin
          state_nxt = ST_RD;
        end
      end
      ST_W_RD: begin
        if (txn_done && txn_nack) begin
          nack_s    = 1'b1;
          state_nxt = ST_NEXT;
        end else if (txn_done) begin
          rd_cap_s  = 1'b1;
          state_nxt = ST_STORE;
        end else begin
          state_nxt = ST_W_RD;
        end
      end
      ST_STORE: begin
        store_s   = 1'b1;
        state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (nxt_s[2]) begin
          adv_s     = 1'b1;
          adv_ch_s  = nxt_s[1:0];
          state_nxt = ST_WR_CFG;
        end else if (scan_en) begin
          adv_s     = 1'b1;
          adv_ch_s  = lowest_set(CH_MASK);
          state_nxt = ST_WR_CFG;
        end else begin
          pass_end_s = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, channel index and captured read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_start    <= 1'b0;
      txn_addr     <= 7'd0;
      txn_rw       <= 1'b0;
      txn_reg      <= 8'h00;
      txn_wdata    <= 16'h0000;
      txn_ptr_only <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_data  <= 16'h0000;
      result_flat  <= 64'd0;
      busy         <= 1'b0;
      err_count    <= 8'd0;
      ch_r         <= 2'd0;
      rdata_r      <= 16'h0000;
    end else begin
      txn_start <= issue_s;
      // Fields change only on a new request, so they stay stable until txn_done
      if (issue_s) begin
        txn_addr     <= I2C_ADDR;
        txn_rw       <= issue_rw_s;
        txn_reg      <= issue_reg_s;
        txn_wdata    <= issue_wdata_s;
        txn_ptr_only <= issue_ptr_s;
      end
      if (pass_start_s) begin
        busy <= 1'b1;
        ch_r <= lowest_set(CH_MASK);
      end else if (adv_s) begin
        ch_r <= adv_ch_s;
      end
      if (pass_end_s) begin
        busy <= 1'b0;
      end
      if (nack_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (rd_cap_s) begin
        rdata_r <= txn_rdata;
      end
      // STORE latches; the strobe is therefore visible in the NEXT cycle
      sample_valid <= store_s;
      if (store_s) begin
        sample_data                      <= rdata_r;
        sample_ch                        <= ch_r;
        result_flat[{ch_r, 4'b0000} +: 16] <= rdata_r;
      end
    end
  end

endmodule
